// File: rtl/gold_field_ctrl.sv
// Level-setup and live-gold bookkeeping for GoldMiner.
// Fills N_GOLD slots with pixel coordinates from distinct LFSR cell codes.
// Tracks which golds are still live and serves hook grabs.
// The renderer reads slots through a one-cycle registered port.
module gold_field_ctrl #(
   parameter int unsigned N_GOLD    = 10,
   parameter int unsigned MAX_TRIES = 40
) (
   input  logic        i_Clk,
   input  logic        rst,
   input  logic        i_Level_Start,
   input  logic [3:0]  i_Cell,
   input  logic        i_Cell_Valid,
   input  logic        i_Grab_Req,
   input  logic [3:0]  i_Grab_Idx,
   input  logic [3:0]  i_Rd_Idx,
   output logic [10:0] o_Rd_X,
   output logic [9:0]  o_Rd_Y,
   output logic        o_Rd_Live,
   output logic        o_Busy,
   output logic        o_Ready,
   output logic        o_Level_Clear,
   output logic [14:0] o_Live_Mask,
   output logic [3:0]  o_Live_Count,
   output logic        o_Grab_Ack,
   output logic        o_Grab_Err
);

   localparam int unsigned TW = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);

   typedef enum logic [1:0] {StIdle, StFill, StReady, StClear} state_e;

   // Cell code -> {x[10:0], y[9:0]} using x = col*126+10, y = row*108+10.
   function automatic logic [20:0] cell_xy(input logic [3:0] c);
      logic [3:0]  col;
      logic [3:0]  row;
      logic [10:0] x;
      logic [9:0]  y;
      unique case (c)
         4'd0:  begin col = 4'd2; row = 4'd4; end
         4'd1:  begin col = 4'd1; row = 4'd3; end
         4'd2:  begin col = 4'd8; row = 4'd3; end
         4'd3:  begin col = 4'd5; row = 4'd3; end
         4'd4:  begin col = 4'd5; row = 4'd4; end
         4'd5:  begin col = 4'd6; row = 4'd4; end
         4'd6:  begin col = 4'd9; row = 4'd5; end
         4'd7:  begin col = 4'd0; row = 4'd4; end
         4'd8:  begin col = 4'd7; row = 4'd4; end
         4'd9:  begin col = 4'd8; row = 4'd5; end
         4'd10: begin col = 4'd9; row = 4'd4; end
         4'd11: begin col = 4'd9; row = 4'd3; end
         4'd12: begin col = 4'd0; row = 4'd5; end
         4'd13: begin col = 4'd1; row = 4'd4; end
         4'd14: begin col = 4'd6; row = 4'd3; end
         default: begin col = 4'd5; row = 4'd5; end
      endcase
      x = 11'(col) * 11'd126 + 11'd10;
      y = 10'(row) * 10'd108 + 10'd10;
      return {x, y};
   endfunction

   function automatic logic [3:0] popcnt(input logic [14:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 15; i++) begin
         n = n + 4'(v[i]);
      end
      return n;
   endfunction

   state_e          state_q, state_d;
   logic [15:0]     used_q, used_d;
   logic [3:0]      k_q, k_d;
   logic [TW-1:0]   tries_q, tries_d;
   logic [14:0]     live_q, live_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [10:0]     x_q [16];
   logic [10:0]     x_d [16];
   logic [9:0]      y_q [16];
   logic [9:0]      y_d [16];
   logic            ack_q, ack_d;
   logic            err_q, err_d;
   logic [10:0]     rd_x_q, rd_x_d;
   logic [9:0]      rd_y_q, rd_y_d;
   logic            rd_live_q, rd_live_d;

   logic            fallback;
   logic            draw_ok;
   logic            wr_en;
   logic [3:0]      low_code;
   logic [3:0]      wr_code;
   logic [20:0]     wr_xy;
   logic            grab_in_range;
   logic            rd_in_range;

   // Lowest code not yet used; scanning downward lets the smallest index win.
   always_comb begin
      low_code = '0;
      for (int i = 15; i >= 0; i--) begin
         if (!used_q[i]) begin
            low_code = 4'(i);
         end
      end
   end

   // Decide whether a slot is written this cycle and from which code.
   always_comb begin
      fallback = (state_q == StFill) && (tries_q == TW'(MAX_TRIES));
      draw_ok  = (state_q == StFill) && !fallback && i_Cell_Valid && !used_q[i_Cell];
      wr_en    = !i_Level_Start && (fallback || draw_ok) && (32'(k_q) < N_GOLD);
      wr_code  = fallback ? low_code : i_Cell;
      wr_xy    = cell_xy(wr_code);
   end

   // Next-state: level start overrides everything, then grabs, then fill progress.
   always_comb begin
      state_d       = state_q;
      used_d        = used_q;
      k_d           = k_q;
      tries_d       = tries_q;
      live_d        = live_q;
      x_d           = x_q;
      y_d           = y_q;
      ack_d         = 1'b0;
      err_d         = 1'b0;
      grab_in_range = (32'(i_Grab_Idx) < N_GOLD);
      if (i_Level_Start) begin
         state_d = StFill;
         used_d  = '0;
         k_d     = '0;
         tries_d = '0;
         live_d  = '0;
         for (int i = 0; i < 16; i++) begin
            x_d[i] = '0;
            y_d[i] = '0;
         end
      end else begin
         if (i_Grab_Req) begin
            if ((state_q == StReady) && grab_in_range && live_q[i_Grab_Idx]) begin
               live_d[i_Grab_Idx] = 1'b0;
               ack_d              = 1'b1;
               if (live_d == '0) begin
                  state_d = StClear;
               end
            end else begin
               err_d = 1'b1;
            end
         end
         if ((state_q == StFill) && !fallback && i_Cell_Valid) begin
            tries_d = tries_q + TW'(1);
         end
         if (wr_en) begin
            x_d[k_q]        = wr_xy[20:10];
            y_d[k_q]        = wr_xy[9:0];
            used_d[wr_code] = 1'b1;
            live_d[k_q]     = 1'b1;
            k_d             = k_q + 4'd1;
         end
         if ((state_q == StFill) && (32'(k_d) >= N_GOLD)) begin
            state_d = StReady;
         end
      end
   end

   // Read port and live count see this cycle's updates so they land one edge later.
   always_comb begin
      rd_in_range = (32'(i_Rd_Idx) < N_GOLD);
      rd_x_d      = rd_in_range ? x_d[i_Rd_Idx] : '0;
      rd_y_d      = rd_in_range ? y_d[i_Rd_Idx] : '0;
      rd_live_d   = rd_in_range ? live_d[i_Rd_Idx] : 1'b0;
      cnt_d       = popcnt(live_d);
   end

   // State and datapath registers.
   always_ff @(posedge i_Clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         used_q    <= '0;
         k_q       <= '0;
         tries_q   <= '0;
         live_q    <= '0;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rd_x_q    <= '0;
         rd_y_q    <= '0;
         rd_live_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         used_q    <= used_d;
         k_q       <= k_d;
         tries_q   <= tries_d;
         live_q    <= live_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rd_x_q    <= rd_x_d;
         rd_y_q    <= rd_y_d;
         rd_live_q <= rd_live_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   assign o_Busy        = (state_q == StFill);
   assign o_Ready       = (state_q == StReady);
   assign o_Level_Clear = (state_q == StClear);
   assign o_Live_Mask   = live_q;
   assign o_Live_Count  = cnt_q;
   assign o_Grab_Ack    = ack_q;
   assign o_Grab_Err    = err_q;
   assign o_Rd_X        = rd_x_q;
   assign o_Rd_Y        = rd_y_q;
   assign o_Rd_Live     = rd_live_q;

endmodule

// File: doc/gold_field_ctrl.md
# gold_field_ctrl

Level-setup and live-gold bookkeeping controller for GoldMiner. On a level start it draws 4-bit cell codes from the LFSR position source, rejects duplicate cells, and loads `N_GOLD` slots with pixel coordinates. During play it tracks which golds are still live, serves hook grab requests, and raises level-clear when none remain. The VGA renderer reads slot coordinates through a registered read port.

## Interface
- `N_GOLD`, default 10: number of gold slots, range 1..15.
- `MAX_TRIES`, default 40: number of valid draws accepted in FILL before the block switches to deterministic fallback fill.
- `i_Clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `i_Level_Start` in 1: single-cycle pulse that starts a new fill.
- `i_Cell` in 4: cell code from the LFSR.
- `i_Cell_Valid` in 1: `i_Cell` is a fresh draw this cycle.
- `i_Grab_Req` in 1: single-cycle request to collect a slot.
- `i_Grab_Idx` in 4: slot index for the grab.
- `i_Rd_Idx` in 4: renderer read index.
- `o_Rd_X` out 11: x coordinate of the slot at `i_Rd_Idx`.
- `o_Rd_Y` out 10: y coordinate of the slot at `i_Rd_Idx`.
- `o_Rd_Live` out 1: the slot at `i_Rd_Idx` is live.
- `o_Busy` out 1: high in FILL.
- `o_Ready` out 1: high in READY.
- `o_Level_Clear` out 1: high in CLEAR.
- `o_Live_Mask` out 15: one bit per slot; bit i set means slot i is live.
- `o_Live_Count` out 4: number of live slots.
- `o_Grab_Ack` out 1: one-cycle pulse, grab accepted.
- `o_Grab_Err` out 1: one-cycle pulse, grab rejected.

## Operation
- Cell code to grid (col,row), codes 0..15 in order: (2,4),(1,3),(8,3),(5,3),(5,4),(6,4),(9,5),(0,4),(7,4),(8,5),(9,4),(9,3),(0,5),(1,4),(6,3),(5,5).
- Pixel coordinates: x = col*126+10, y = row*108+10. Maximum values are 1144 and 550, which fit 11 and 10 bits. Compute with no truncation.
- States: IDLE, FILL, READY, CLEAR. Reset enters IDLE.
- From any state, `i_Level_Start` does the following, then enters FILL:
  - clears the 16-bit used-code mask, slot pointer k, try counter, `o_Live_Mask`, and all slot coordinates (set to 0);
  - cancels any pending grab response.
- FILL, on each cycle with `i_Cell_Valid`:
  - increment the try counter;
  - if code c is unused: write slot k from c, set used[c], set live bit k, k++;
  - if code c is used: discard it.
- FILL fallback: once tries reach `MAX_TRIES` and k<`N_GOLD`, write the lowest unused code to slot k, one slot per cycle, ignoring `i_Cell`.
- FILL exits to READY when k reaches `N_GOLD`.
- READY, grab with idx<`N_GOLD` and live bit set: clear the bit and pulse `o_Grab_Ack`. If this clears the last live bit, go to CLEAR.
- Any other grab pulses `o_Grab_Err`. This covers a dead slot, idx≥`N_GOLD`, and state≠READY.
- CLEAR holds until `i_Level_Start`.
- Read port: for idx≥`N_GOLD`, or a slot not yet written, output x=0, y=0, live=0.
- `o_Live_Count` equals the popcount of `o_Live_Mask`, registered with the mask.

## Timing
- Reset values: every output 0, all slots 0, state IDLE.
- `i_Level_Start` at edge t gives `o_Busy`=1 from t+1.
- An accepted draw at edge t makes the slot readable and sets its live bit from t+1.
- `o_Ready` rises the cycle after slot `N_GOLD`-1 is written. `o_Busy` falls the same cycle.
- Grab at edge t gives its Ack/Err pulse at t+1. `o_Live_Mask`, `o_Live_Count` and the CLEAR transition also update at t+1. Accept back-to-back grabs every cycle.
- Read latency is one cycle: `i_Rd_Idx` sampled at edge t appears on `o_Rd_*` after edge t.
- A grab coinciding with `i_Level_Start`: start wins, and the grab produces neither Ack nor Err.
- Reset mid-FILL or mid-play: immediate return to reset values. No partial slot survives.
- `i_Cell_Valid` outside FILL is ignored.
- Worst-case fill time: `MAX_TRIES` valid cycles plus `N_GOLD` fallback cycles.

## Test plan
- Reset, then start, then 10 distinct codes 0..9, one per cycle -> `o_Ready`=1 one cycle after the last code. Slot 0 reads (262,442); slot 6 reads (1144,550); mask=0x3FF; count=10.
- Start, then codes 3,3,3,7,… -> only the first 3 is stored. Slot 0=(640,334), slot 1=(10,442). Try counter shows 4 after 4 draws.
- Start, then `i_Cell`=5 held constant -> slot 0 from code 5. After 40 tries, slots 1..9 filled with codes 0,1,2,3,4,6,7,8,9 on 9 consecutive cycles. Then `o_Ready`.
- READY with a full field: grab idx 4 -> Ack; mask=0x3EF, count=9. Grab idx 4 again -> Err. Grab idx 12 -> Err. Grab the remaining 9 back-to-back -> `o_Level_Clear` at the cycle after the last Ack.
- Grab together with start in READY -> no Ack or Err, FILL entered, mask=0. Grab during FILL -> Err.
- Drive `rst` low mid-fill after 5 slots -> all outputs 0 asynchronously, state IDLE. Read idx 2 -> (0,0,0).
